// File: rtl/inst_mem_loader_pkg.sv
// inst_loader_pkg: shared loader FSM states and stream-format constants
package inst_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, WRITE, CHK, DONE, ERR} loader_state_t;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: byte stream in and instruction-memory word write port out
interface inst_mem_loader_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    modport slave (input s_valid, s_data, output s_ready, mem_we, mem_addr, mem_wdata);
    modport master (output s_valid, s_data, input s_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/inst_mem_loader_byte_word_packer.sv
// byte_word_packer: assembles four stream bytes little-endian into one word
module byte_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_full
);
    logic [1:0]  lane;
    logic [23:0] acc;
    // The fourth byte is never stored; it completes the word combinationally.
    assign word_full = en && lane == 2'd3;
    assign word = {din, acc};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            acc  <= '0;
        end else if (clear) begin
            lane <= '0;
            acc  <= '0;
        end else if (en) begin
            lane <= lane + 2'd1;
            acc  <= lane == 2'd0 ? {acc[23:8], din} :
                    lane == 2'd1 ? {acc[23:16], din, acc[7:0]} :
                    lane == 2'd2 ? {din, acc[15:0]} : acc;
        end
    end
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: loads a checksummed byte-stream image into instruction memory, holding the core until verified
module inst_mem_loader
    import inst_loader_pkg::*;
#(
    parameter int MEM_BYTES = 88,
    parameter int BASE_ADDR = 0,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    inst_mem_loader_if.slave    bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                cpu_hold
);
    localparam int MAX_WORDS = MEM_BYTES / BYTES_PER_WORD;
    loader_state_t    state, nxt;
    logic [CNT_W-1:0] cnt, word_idx, hdr;
    logic [7:0]       xsum;
    logic [31:0]      word;
    logic             acc, arm, word_full;
    assign bus.s_ready = state == HDR_LO || state == HDR_HI || state == DATA || state == CHK;
    assign acc       = bus.s_valid && bus.s_ready;
    assign arm       = start && (state == IDLE || state == DONE || state == ERR);
    assign hdr       = CNT_W'({bus.s_data, cnt[7:0]});
    assign bus.mem_we = state == WRITE;
    assign busy      = bus.s_ready || state == WRITE;
    assign done      = state == DONE;
    assign err       = state == ERR;
    assign cpu_hold  = state != DONE;
    byte_word_packer u_packer (
        .clk(clk), .rst_n(rst_n), .clear(arm), .en(acc && state == DATA),
        .din(bus.s_data), .word(word), .word_full(word_full)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: nxt = arm ? HDR_LO : state;
            HDR_LO: nxt = acc ? HDR_HI : state;
            HDR_HI: nxt = !acc ? state : hdr == '0 ? CHK : hdr > CNT_W'(MAX_WORDS) ? ERR : DATA;
            DATA:   nxt = word_full ? WRITE : state;
            WRITE:  nxt = word_idx + CNT_W'(1) == cnt ? CHK : DATA;
            CHK:    nxt = !acc ? state : bus.s_data == xsum ? DONE : ERR;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            word_idx      <= '0;
            xsum          <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            if (arm) begin
                word_idx <= '0;
                xsum     <= '0;
            end
            if (acc && state == HDR_LO) cnt[7:0] <= bus.s_data;
            if (acc && state == HDR_HI) cnt <= hdr;
            if (acc && state == DATA) xsum <= xsum ^ bus.s_data;
            // Address and data are captured with the completing byte so they hold after the strobe.
            if (word_full) begin
                bus.mem_addr  <= 32'(BASE_ADDR) + 32'({word_idx, 2'b00});
                bus.mem_wdata <= word;
            end
            if (state == WRITE) word_idx <= word_idx + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed and randomized image loads checked against a word-list reference model
module tb_inst_mem_loader;
    localparam int MAXW = 22;
    logic clk = 0, rst_n = 0, start = 0;
    logic busy, done, err, cpu_hold;
    int total = 0, bad = 0, cyc = 0;
    logic [31:0] img [0:63];
    logic [31:0] wa_q[$], wd_q[$];
    int wc_q[$];
    inst_mem_loader_if bus ();
    inst_mem_loader dut (.clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
                         .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.mem_we === 1'b1) begin
        wa_q.push_back(bus.mem_addr);
        wd_q.push_back(bus.mem_wdata);
        wc_q.push_back(cyc);
    end
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        if (gaps) repeat ($urandom_range(0, 3)) begin
            bus.s_valid = 0;
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        start = 0;
        bus.s_valid = 1;
        bus.s_data = b;
        forever begin
            @(negedge clk);
            if (bus.s_ready === 1'b1) break;
            if (++t > 50) begin
                check("byte_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        bus.s_valid = 0;
    endtask
    task automatic pulse_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask
    task automatic run_image(input int n, input bit flip, input bit gaps, input bit timing);
        logic [7:0] x = 0;
        logic [7:0] b;
        bit ok = !flip;
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        pulse_start();
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
        if (n > MAXW) begin
            @(negedge clk);
            check("ovf_err", err, 1);
            check("ovf_ready", bus.s_ready, 0);
            check("ovf_hold", cpu_hold, 1);
            repeat (10) @(negedge clk);
            check("ovf_nowrite", wa_q.size(), 0);
            return;
        end
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) begin
                b = img[i][8*k +: 8];
                x ^= b;
                send_byte(b, gaps);
            end
        send_byte(x ^ {7'b0, flip}, gaps);
        @(negedge clk);
        check("end_done", done, ok);
        check("end_err", err, !ok);
        check("end_hold", cpu_hold, !ok);
        check("end_busy", busy, 0);
        check("wr_count", wa_q.size(), n);
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            check($sformatf("wr_addr%0d", i), wa_q[i], 4 * i);
            check($sformatf("wr_data%0d", i), wd_q[i], img[i]);
            if (timing && i > 0) check($sformatf("wr_gap%0d", i), wc_q[i] - wc_q[i-1], 5);
        end
        if (n > 0) check("addr_hold", bus.mem_addr, 4 * (n - 1));
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, bus.s_ready, 0);
        check({tag, "_we"}, bus.mem_we, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_wdata"}, bus.mem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_hold"}, cpu_hold, 1);
    endtask
    initial begin
        bus.s_valid = 0;
        bus.s_data = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1;
        @(negedge clk);
        bus.s_valid = 1;
        start = 1;
        @(negedge clk);
        check("idle_start_ready", bus.s_ready, 1);
        check("idle_start_busy", busy, 1);
        bus.s_valid = 0;
        start = 0;
        rst_n = 0;
        #1 rst_n = 1;
        img[0] = 32'h00000913;
        img[1] = 32'h00140413;
        run_image(2, 0, 0, 1);
        for (int i = 0; i < 64; i++) img[i] = $urandom;
        run_image(MAXW, 0, 0, 1);
        run_image(MAXW + 1, 0, 0, 0);
        for (int i = 0; i < 64; i++) img[i] = $urandom;
        run_image(5, 1, 0, 0);
        pulse_start();
        @(negedge clk);
        check("restart_busy", busy, 1);
        check("restart_ready", bus.s_ready, 1);
        check("restart_err", err, 0);
        for (int i = 0; i < 64; i++) img[i] = $urandom;
        run_image(6, 0, 1, 0);
        run_image(6, 0, 0, 1);
        run_image(0, 0, 0, 0);
        for (int i = 0; i < 64; i++) img[i] = $urandom;
        pulse_start();
        send_byte(8'd3, 0);
        send_byte(8'd0, 0);
        for (int k = 0; k < 6; k++) send_byte(img[k / 4][8*(k%4) +: 8], 0);
        @(negedge clk);
        rst_n = 0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 64; i++) img[i] = $urandom;
        run_image(3, 0, 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
